inst_cache: RTL and testbench

Read-only instruction cache between the CPU fetch stage and the AXI-style read bus. Serves fetches from a 2-way set-associative array (8-word lines), refills misses with an 8-beat burst, and bypasses the array for uncached addresses. Also supports a flush that cancels the in-flight fetch response.

---
 rtl/inst_cache_pkg.sv | 21 ++
 rtl/icache_way.sv | 50 +++++
 rtl/inst_cache.sv | 194 +++++++++++++++++++
 tb/tb_inst_cache.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// inst_cache shared constants and FSM state encoding.
// Geometry: 32 B lines, 128 sets, 20-bit tags.
package inst_cache_pkg;

  localparam int OFFSET_WIDTH = 5;
  localparam int INDEX_WIDTH  = 7;
  localparam int TAG_WIDTH    = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int LINE_WORDS   = 8;
  localparam int WORD_BITS    = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_UC_AR,
    S_UC_R,
    S_RESP
  } state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid bits, tags and line data.
// Reads are combinational on the set index; writes land on the clock.
module icache_way #(
  parameter int INDEX_WIDTH = inst_cache_pkg::INDEX_WIDTH,
  parameter int TAG_WIDTH   = inst_cache_pkg::TAG_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INDEX_WIDTH-1:0]              index,
  input  logic [inst_cache_pkg::WORD_BITS-1:0] word,
  output logic                                rd_valid,
  output logic [TAG_WIDTH-1:0]                rd_tag,
  output logic [31:0]                         rd_data,
  input  logic                                wr_en,
  input  logic [inst_cache_pkg::WORD_BITS-1:0] wr_word,
  input  logic [31:0]                         wr_data,
  input  logic                                line_en,
  input  logic                                line_valid,
  input  logic [TAG_WIDTH-1:0]                line_tag
);
  import inst_cache_pkg::*;

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [SETS-1:0]      valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [SETS];
  logic [31:0]          data_q [SETS][LINE_WORDS];

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index][word];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_en) begin
      valid_q[index] <= line_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (line_en) begin
      tag_q[index] <= line_tag;
    end
    if (wr_en) begin
      data_q[index][wr_word] <= wr_data;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// 2-way set-associative read-only instruction cache with burst refill,
// uncached bypass and flush of the in-flight fetch response.
module inst_cache #(
  parameter int OFFSET_WIDTH = inst_cache_pkg::OFFSET_WIDTH,
  parameter int INDEX_WIDTH  = inst_cache_pkg::INDEX_WIDTH,
  parameter int WAYS         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic        flush,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready
);
  import inst_cache_pkg::*;

  localparam int TAG_W = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int SETS  = 1 << INDEX_WIDTH;

  state_t               state_q;
  state_t               state_d;
  logic [31:0]          addr_q;
  logic                 cached_q;
  logic                 flushed_q;
  logic                 victim_q;
  logic [WORD_BITS:0]   cnt_q;
  logic [31:0]          uc_data_q;
  logic [SETS-1:0]      lru_q;

  logic [TAG_W-1:0]       tag;
  logic [INDEX_WIDTH-1:0] index;
  logic [WORD_BITS-1:0]   word;
  logic [31:0]            line_addr;

  assign tag       = addr_q[31 -: TAG_W];
  assign index     = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign word      = addr_q[2 +: WORD_BITS];
  assign line_addr = {addr_q[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

  logic [WAYS-1:0] way_valid;
  logic [WAYS-1:0] hit;
  logic [TAG_W-1:0] way_tag  [WAYS];
  logic [31:0]      way_data [WAYS];

  logic beat_ok;
  logic fill_beat;
  logic hit_any;
  logic hit_way;
  logic victim_d;

  // Beats past the eighth leave the counter saturated and are dropped.
  assign beat_ok   = m_rvalid && !cnt_q[WORD_BITS];
  assign fill_beat = (state_q == S_MISS_R) && beat_ok;
  assign hit_any   = |hit;
  assign hit_way   = hit[1];
  assign victim_d  = !way_valid[0] ? 1'b0 :
                     !way_valid[1] ? 1'b1 : lru_q[index];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic sel;
    assign sel    = (victim_q == 1'(w));
    assign hit[w] = way_valid[w] && (way_tag[w] == tag);

    icache_way #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_W)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .index      (index),
      .word       (word),
      .rd_valid   (way_valid[w]),
      .rd_tag     (way_tag[w]),
      .rd_data    (way_data[w]),
      .wr_en      (fill_beat && sel),
      .wr_word    (cnt_q[WORD_BITS-1:0]),
      .wr_data    (m_rdata),
      .line_en    (fill_beat && sel && (m_rlast || cnt_q == '0)),
      .line_valid (m_rlast),
      .line_tag   (tag)
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cached_q  <= 1'b0;
      flushed_q <= 1'b0;
      victim_q  <= 1'b0;
      cnt_q     <= '0;
      uc_data_q <= '0;
      lru_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && s_arvalid) begin
        addr_q   <= s_araddr;
        cached_q <= cache_ena;
      end
      if (state_q == S_IDLE) begin
        flushed_q <= 1'b0;
      end else if (flush) begin
        flushed_q <= 1'b1;
      end
      if (state_q == S_LOOKUP) begin
        victim_q <= victim_d;
      end
      if (state_q == S_MISS_R || state_q == S_UC_R) begin
        if (beat_ok) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (state_q == S_UC_R && m_rvalid && cnt_q == '0) begin
        uc_data_q <= m_rdata;
      end
      // LRU bit names the way to evict next.
      if (state_q == S_LOOKUP && hit_any && !flush) begin
        lru_q[index] <= ~hit_way;
      end
      if (fill_beat && m_rlast) begin
        lru_q[index] <= ~victim_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (s_arvalid && !flush) begin
          state_d = cache_ena ? S_LOOKUP : S_UC_AR;
        end
      end
      S_LOOKUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (hit_any) begin
          s_rvalid = 1'b1;
          s_rdata  = way_data[hit_way];
          state_d  = S_IDLE;
        end else begin
          m_arvalid = 1'b1;
          m_araddr  = line_addr;
          state_d   = m_arready ? S_MISS_R : S_MISS_AR;
        end
      end
      S_MISS_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = line_addr;
        if (m_arready) state_d = S_MISS_R;
      end
      S_MISS_R: begin
        m_rready = 1'b1;
        if (m_rvalid && m_rlast) begin
          state_d = (flushed_q || flush) ? S_IDLE : S_RESP;
        end
      end
      S_UC_AR: begin
        m_arvalid = 1'b1;
        m_araddr  = addr_q;
        if (m_arready) state_d = S_UC_R;
      end
      S_UC_R: begin
        m_rready = 1'b1;
        if (m_rvalid && m_rlast) begin
          state_d = (flushed_q || flush) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (!flush && !flushed_q) begin
          s_rvalid = 1'b1;
          s_rdata  = cached_q ? way_data[victim_q] : uc_data_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed table, flush/reset
// sequences and random fetches against a recency-list cache model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_ena;
  logic        flush;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;

  int checks = 0;
  int failures = 0;
  int exp_rv = 0;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cache_ena (cache_ena),
    .flush     (flush),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_rdata   (s_rdata),
    .s_rvalid  (s_rvalid),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rvalid  (m_rvalid),
    .m_rlast   (m_rlast),
    .m_rready  (m_rready)
  );

  int          cyc = 0;
  int          ar_cnt = 0;
  int          beat_cnt = 0;
  int          rv_cnt = 0;
  int          rlast_cyc = -10;
  int          viol = 0;
  logic [31:0] last_ar = '0;
  bit          bus_abort = 1'b0;
  bit          bus_slow = 1'b0;

  // Cycle monitor, sampled late in each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (m_arvalid && m_arready) begin
        ar_cnt++;
        last_ar = m_araddr;
      end
      if (m_rvalid && m_rready) begin
        beat_cnt++;
        if (m_rlast) rlast_cyc = cyc;
      end
      if (s_rvalid) rv_cnt++;
      if ((m_arvalid && m_rready) || (s_rvalid && flush)) viol++;
    end
  end

  // Bus slave: beat k of a burst at base B carries B + 4k, rlast on beat 8.
  initial begin
    int          phase;
    int          k;
    logic [31:0] base;
    phase = 0;
    k = 0;
    base = '0;
    m_arready = 1'b0;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus_abort) begin
        phase = 0;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rlast = 1'b0;
      end else if (phase == 0) begin
        if (m_arvalid && (!bus_slow || $urandom_range(0, 1) == 1)) begin
          m_arready = 1'b1;
          base = m_araddr;
          phase = 1;
        end else begin
          m_arready = 1'b0;
        end
      end else begin
        if (phase == 1) begin
          m_arready = 1'b0;
          phase = 2;
          k = 0;
        end else if (m_rvalid) begin
          k++;
        end
        if (k == 8) begin
          phase = 0;
          m_rvalid = 1'b0;
          m_rlast = 1'b0;
        end else if (bus_slow && $urandom_range(0, 2) == 0) begin
          m_rvalid = 1'b0;
          m_rlast = 1'b0;
        end else begin
          m_rvalid = 1'b1;
          m_rdata = base + 32'(4 * k);
          m_rlast = (k == 7);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " s_rvalid"}, 32'(s_rvalid), 32'd0);
    chk({nm, " s_rdata"}, s_rdata, 32'd0);
    chk({nm, " m_arvalid"}, 32'(m_arvalid), 32'd0);
    chk({nm, " m_araddr"}, m_araddr, 32'd0);
    chk({nm, " m_rready"}, 32'(m_rready), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic ena,
                         output logic [31:0] d, output int lat);
    @(negedge clk);
    s_araddr = a;
    cache_ena = ena;
    s_arvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = -1;
    d = '0;
    for (int i = 1; i <= 300; i++) begin
      #4;
      if (s_rvalid) begin
        lat = i;
        d = s_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic ena,
                        input bit miss, input logic [31:0] ar,
                        input string nm);
    int          a0;
    int          lat;
    logic [31:0] d;
    a0 = ar_cnt;
    do_read(a, ena, d, lat);
    exp_rv++;
    chk({nm, " responded"}, 32'(lat > 0), 32'd1);
    if (lat > 0) begin
      chk({nm, " data"}, d, a);
      chk({nm, " bus reqs"}, 32'(ar_cnt - a0), 32'(miss));
      if (miss) begin
        chk({nm, " araddr"}, last_ar, ar);
        chk({nm, " rlast->rvalid"}, 32'(cyc), 32'(rlast_cyc + 1));
      end else begin
        chk({nm, " hit latency"}, 32'(lat), 32'd1);
      end
    end
  endtask

  task automatic wait_rready(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      #4;
      if (m_rready) got = 1'b1;
      @(negedge clk);
    end
  endtask

  // Reference model: per set, tags ordered most- to least-recently used.
  logic [19:0] rec [128][$];

  function automatic bit model_miss(input logic [31:0] a);
    int          idx;
    logic [19:0] t;
    idx = int'(a[11:5]);
    t = a[31:12];
    for (int i = 0; i < rec[idx].size(); i++) begin
      if (rec[idx][i] == t) begin
        rec[idx].delete(i);
        rec[idx].push_front(t);
        return 1'b0;
      end
    end
    rec[idx].push_front(t);
    if (rec[idx].size() > 2) void'(rec[idx].pop_back());
    return 1'b1;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        ena;
    bit          miss;
    logic [31:0] ar;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit got;
    int r0;
    int b0;
    vecs = '{
      '{32'hF000_0000, 1'b1, 1'b1, 32'hF000_0000},
      '{32'hF000_0004, 1'b1, 1'b0, 32'h0},
      '{32'hF000_0008, 1'b1, 1'b0, 32'h0},
      '{32'hF000_000C, 1'b1, 1'b0, 32'h0},
      '{32'hF000_0040, 1'b1, 1'b1, 32'hF000_0040},
      '{32'hF000_1040, 1'b1, 1'b1, 32'hF000_1040},
      '{32'hF000_2040, 1'b1, 1'b1, 32'hF000_2040},
      '{32'hF000_1040, 1'b1, 1'b0, 32'h0},
      '{32'hF000_0040, 1'b1, 1'b1, 32'hF000_0040},
      '{32'h1FC0_0008, 1'b0, 1'b1, 32'h1FC0_0008},
      '{32'h1FC0_0008, 1'b0, 1'b1, 32'h1FC0_0008},
      '{32'hF000_001C, 1'b1, 1'b0, 32'h0}
    };

    rst = 1'b1;
    cache_ena = 1'b0;
    flush = 1'b0;
    s_arvalid = 1'b0;
    s_araddr = '0;
    repeat (3) @(negedge clk);
    #4;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      access(vecs[i].addr, vecs[i].ena, vecs[i].miss, vecs[i].ar,
             $sformatf("vec%0d", i));
    end

    // Flush during refill: no response, but the line is installed.
    r0 = rv_cnt;
    b0 = beat_cnt;
    @(negedge clk);
    s_araddr = 32'hF000_5000;
    cache_ena = 1'b1;
    s_arvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    wait_rready(got);
    chk("flush reached refill", 32'(got), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (20) @(negedge clk);
    chk("flush no rvalid", 32'(rv_cnt - r0), 32'd0);
    chk("flush burst done", 32'(beat_cnt - b0), 32'd8);
    access(32'hF000_5004, 1'b1, 1'b0, 32'h0, "after flush");

    // Reset mid-burst, then a previously cached line must miss.
    @(negedge clk);
    s_araddr = 32'hF000_6000;
    cache_ena = 1'b1;
    s_arvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    wait_rready(got);
    chk("reset reached refill", 32'(got), 32'd1);
    rst = 1'b1;
    bus_abort = 1'b1;
    @(negedge clk);
    #4;
    chk_idle_outputs("mid-burst reset");
    @(negedge clk);
    rst = 1'b0;
    bus_abort = 1'b0;
    access(32'hF000_0014, 1'b1, 1'b1, 32'hF000_0000, "critical word");
    access(32'hF000_0004, 1'b1, 1'b0, 32'h0, "post-reset hit");

    // Random fetches on a slow, bursty bus from a fresh cache.
    @(negedge clk);
    rst = 1'b1;
    bus_slow = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (rec[i]) rec[i].delete();
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic        e;
      bit          m;
      a = 32'hF000_0000 | (32'($urandom_range(0, 3)) << 12)
        | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      e = ($urandom_range(0, 7) != 0);
      m = e ? model_miss(a) : 1'b1;
      access(a, e, m, e ? {a[31:5], 5'b0} : a, $sformatf("rand%0d", n));
    end

    repeat (5) @(negedge clk);
    chk("protocol violations", 32'(viol), 32'd0);
    chk("rvalid pulse count", 32'(rv_cnt), 32'(exp_rv));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
